stream_reduce: RTL
==================

STREAM_REDUCE -- requirements
Module: stream_reduce

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, element and sum width.
REQ-002 SHALL have parameter COUNT_WIDTH, default 32, element-count width.
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 SHALL have port in0_valid  input  1  upstream token valid.
REQ-006 SHALL have port in0_ready  output  1  block accepts token this cycle.
REQ-007 SHALL have port in0_data_field0  input  DATA_WIDTH  element value, unsigned.
REQ-008 SHALL have port in0_data_field1  input  1  EOS flag; when 1, field0 is ignored.
REQ-009 SHALL have port out0_valid  output  1  result tuple valid.
REQ-010 SHALL have port out0_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out0_data_field0  output  DATA_WIDTH  sum of elements.
REQ-012 SHALL have port out0_data_field1  output  COUNT_WIDTH  element count.
REQ-013 SHALL have port out0_data_field2  output  DATA_WIDTH  unsigned minimum.
REQ-014 SHALL have port out0_data_field3  output  DATA_WIDTH  unsigned maximum.
REQ-015 SHALL have port out0_data_field4  output  1  empty-stream flag (count == 0).

Function
REQ-016 SHALL implement a two-state FSM: ACCUM and EMIT.
REQ-017 In ACCUM, in0_ready SHALL be 1 and out0_valid SHALL be 0.
REQ-018 A token transfers only when in0_valid && in0_ready; no other input edge changes state.
REQ-019 On an element transfer (field1 == 0): sum += value mod 2^DATA_WIDTH; count += 1, saturating at all-ones; min and max update by unsigned compare.
REQ-020 On an EOS transfer: results latch into output registers, accumulators clear to initial values, FSM goes to EMIT; out0_valid SHALL be 1 the next cycle (latency 1).
REQ-021 In EMIT, in0_ready SHALL be 0, out0_valid SHALL be 1, and all out0_data fields SHALL stay stable until out0_valid && out0_ready.
REQ-022 On the result handshake, the FSM SHALL return to ACCUM and out0_valid SHALL drop the next cycle; the next stream starts from cleared accumulators.
REQ-023 Accumulator initial values: sum 0, count 0, min all-ones, max 0.
REQ-024 An EOS with no preceding elements SHALL emit sum 0, count 0, min all-ones, max 0, empty 1.
REQ-025 An element equal to the running min or max SHALL leave it unchanged; a single element SHALL set both min and max to its value.
REQ-026 out0_valid SHALL NOT depend combinationally on out0_ready; in0_ready SHALL NOT depend combinationally on in0_valid.

Reset
REQ-027 While reset == 0: FSM = ACCUM, accumulators at initial values, out0_valid = 0, all out0_data fields = 0, in0_ready = 0.
REQ-028 Reset assertion mid-stream or during EMIT SHALL discard partial results and any pending tuple immediately, without waiting for a clock edge.
REQ-029 in0_ready SHALL become 1 on the first rising clock edge after reset deasserts.

Structure
REQ-030 Package stream_reduce_pkg SHALL hold the FSM state enum and default DATA_WIDTH/COUNT_WIDTH constants.
REQ-031 Implementation SHALL be a single module; a sub-module is not required.

Verification
REQ-032 Stream 3, 7, 1, EOS, out0_ready held 1 -> one tuple: sum 11, count 3, min 1, max 7, empty 0.
REQ-033 EOS only -> sum 0, count 0, min 0xFFFF_FFFF_FFFF_FFFF, max 0, empty 1.
REQ-034 Elements 0xFFFF_FFFF_FFFF_FFFF and 2, EOS -> sum 1 (wrap), count 2, min 2, max 0xFFFF_FFFF_FFFF_FFFF.
REQ-035 Stream 5, EOS with out0_ready low for 4 cycles -> out0_valid held, fields stable, in0_ready 0 throughout; a second stream 9, EOS then yields sum 9, count 1.
REQ-036 Reset pulse after elements 4, 4 (before EOS), then stream 6, EOS -> sum 6, count 1; no stale tuple emitted.
REQ-037 in0_valid toggled randomly on stream 10, 20, EOS -> sum 30, count 2, identical to gap-free case.

Source files
------------

// File: rtl/stream_reduce_pkg.sv
// Shared types and default widths for the stream reduction block.
package stream_reduce_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 64;
  localparam int unsigned DEF_COUNT_WIDTH = 32;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_e;

endpackage

// File: rtl/stream_reduce.sv
// Reduces an EOS-terminated element stream to {sum, count, min, max, empty}.
// Result appears one cycle after EOS and is held until accepted; input stalls while a result is pending.
module stream_reduce
  import stream_reduce_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in0_valid,
  output logic                   in0_ready,
  input  logic [DATA_WIDTH-1:0]  in0_data_field0,
  input  logic                   in0_data_field1,
  output logic                   out0_valid,
  input  logic                   out0_ready,
  output logic [DATA_WIDTH-1:0]  out0_data_field0,
  output logic [COUNT_WIDTH-1:0] out0_data_field1,
  output logic [DATA_WIDTH-1:0]  out0_data_field2,
  output logic [DATA_WIDTH-1:0]  out0_data_field3,
  output logic                   out0_data_field4
);

  state_e state_q, state_d;

  // Held low through reset and released by the first clock edge afterwards.
  logic live_q;

  logic [DATA_WIDTH-1:0]  sum_q, sum_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  min_q, min_d;
  logic [DATA_WIDTH-1:0]  max_q, max_d;

  logic [DATA_WIDTH-1:0]  res_sum_q;
  logic [COUNT_WIDTH-1:0] res_cnt_q;
  logic [DATA_WIDTH-1:0]  res_min_q;
  logic [DATA_WIDTH-1:0]  res_max_q;
  logic                   res_empty_q;

  logic in_fire;
  logic eos_fire;
  logic elem_fire;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ACCUM;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    in0_ready  = 1'b0;
    out0_valid = 1'b0;
    case (state_q)
      ST_ACCUM: begin
        in0_ready = live_q;
        if (in0_valid && live_q && in0_data_field1) begin
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out0_valid = 1'b1;
        if (out0_ready) begin
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  assign in_fire   = in0_valid && in0_ready;
  assign eos_fire  = in_fire && in0_data_field1;
  assign elem_fire = in_fire && !in0_data_field1;

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    min_d = min_q;
    max_d = max_q;
    if (elem_fire) begin
      sum_d = sum_q + in0_data_field0;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + COUNT_WIDTH'(1);
      end
      if (in0_data_field0 < min_q) begin
        min_d = in0_data_field0;
      end
      if (in0_data_field0 > max_q) begin
        max_d = in0_data_field0;
      end
    end else if (eos_fire) begin
      sum_d = '0;
      cnt_d = '0;
      min_d = '1;
      max_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q       <= '0;
      cnt_q       <= '0;
      min_q       <= '1;
      max_q       <= '0;
      res_sum_q   <= '0;
      res_cnt_q   <= '0;
      res_min_q   <= '0;
      res_max_q   <= '0;
      res_empty_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      min_q <= min_d;
      max_q <= max_d;
      // Result registers only move on EOS, so they stay stable across an EMIT stall.
      if (eos_fire) begin
        res_sum_q   <= sum_q;
        res_cnt_q   <= cnt_q;
        res_min_q   <= min_q;
        res_max_q   <= max_q;
        res_empty_q <= (cnt_q == '0);
      end
    end
  end

  assign out0_data_field0 = res_sum_q;
  assign out0_data_field1 = res_cnt_q;
  assign out0_data_field2 = res_min_q;
  assign out0_data_field3 = res_max_q;
  assign out0_data_field4 = res_empty_q;

endmodule
